// File: rtl/font_pkg.sv
// Shared font constants and loader state encoding, also used by the GPU font reader.
package font_pkg;
  localparam int CHAR_W      = 8;
  localparam int GLYPH_ROWS  = 16;
  localparam int CELL_H      = 20;
  localparam int GLYPH_COUNT = 256;
  localparam int LOADED_W    = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROWS  = 2'd1,
    CHECK = 2'd2,
    WRITE = 2'd3
  } state_e;
endpackage

// File: rtl/font_ram_loader.sv
// Glyph frame loader: code, 16 row bytes, XOR checksum -> one verified write into the font RAM.
module font_ram_loader #(
  parameter int  GLYPH_COUNT = font_pkg::GLYPH_COUNT,
  parameter int  CHAR_W      = font_pkg::CHAR_W,
  parameter int  GLYPH_ROWS  = font_pkg::GLYPH_ROWS,
  localparam int ADDR_W      = $clog2(GLYPH_COUNT),
  localparam int CNT_W       = $clog2(GLYPH_ROWS),
  localparam int GLYPH_BITS  = CHAR_W * GLYPH_ROWS,
  localparam int LOADED_W    = font_pkg::LOADED_W
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic [CHAR_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  abort,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [0:GLYPH_BITS-1] wr_data,
  output logic                  busy,
  output logic                  err,
  output logic [LOADED_W-1:0]   glyphs_loaded
);
  import font_pkg::state_e;
  import font_pkg::IDLE;
  import font_pkg::ROWS;
  import font_pkg::CHECK;
  import font_pkg::WRITE;

  state_e                r_state, w_next;
  logic [CNT_W-1:0]      r_row_cnt;
  logic [CHAR_W-1:0]     r_xor;
  logic [ADDR_W-1:0]     r_code;
  logic [0:GLYPH_BITS-1] r_glyph;

  logic                  r_in_ready, r_busy, r_wr_en, r_err;
  logic [ADDR_W-1:0]     r_wr_addr;
  logic [0:GLYPH_BITS-1] r_wr_data;
  logic [LOADED_W-1:0]   r_loaded;

  logic w_xfer, w_kill, w_take, w_last_row, w_sum_ok;
  logic w_ready_d, w_busy_d, w_wr_en_d, w_err_d;

  // Abort is ignored in IDLE, so a byte arriving there always starts a frame.
  assign w_xfer     = in_valid & r_in_ready;
  assign w_kill     = abort & (r_state != IDLE);
  assign w_take     = w_xfer & ~w_kill;
  assign w_last_row = (r_row_cnt == CNT_W'(GLYPH_ROWS - 1));
  assign w_sum_ok   = (in_data == r_xor);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_xfer) w_next = ROWS;
      ROWS:    if (w_take && w_last_row) w_next = CHECK;
      CHECK:   if (w_take) w_next = w_sum_ok ? WRITE : IDLE;
      WRITE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_kill) w_next = IDLE;
  end

  // Outputs are registered from the next-state decode so they line up with the state.
  always_comb begin
    w_ready_d = (w_next != WRITE);
    w_busy_d  = (w_next != IDLE);
    w_wr_en_d = (w_next == WRITE);
    w_err_d   = (r_state == CHECK) & w_take & ~w_sum_ok;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_row_cnt <= '0;
      r_xor     <= '0;
      r_code    <= '0;
      r_glyph   <= '0;
    end else if (w_take) begin
      case (r_state)
        IDLE: begin
          r_code    <= ADDR_W'(in_data);
          r_row_cnt <= '0;
          r_xor     <= in_data;
        end
        ROWS: begin
          r_glyph[r_row_cnt*CHAR_W +: CHAR_W] <= in_data;
          r_xor     <= r_xor ^ in_data;
          r_row_cnt <= r_row_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_en    <= 1'b0;
      r_err      <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_loaded   <= '0;
    end else begin
      r_in_ready <= w_ready_d;
      r_busy     <= w_busy_d;
      r_wr_en    <= w_wr_en_d;
      r_err      <= w_err_d;
      if (w_wr_en_d) begin
        r_wr_addr <= r_code;
        r_wr_data <= r_glyph;
      end
      if (r_state == WRITE && r_loaded != '1) r_loaded <= r_loaded + 1'b1;
    end
  end

  assign in_ready      = r_in_ready;
  assign busy          = r_busy;
  assign wr_en         = r_wr_en;
  assign err           = r_err;
  assign wr_addr       = r_wr_addr;
  assign wr_data       = r_wr_data;
  assign glyphs_loaded = r_loaded;
endmodule

// File: tb/tb_font_ram_loader.sv
// Randomized bench for font_ram_loader against a frame-level model of the glyph writes.
module tb_font_ram_loader;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_valid = 1'b0;
  logic         abort = 1'b0;
  logic         in_ready, wr_en, busy, err;
  logic [7:0]   wr_addr;
  logic [0:127] wr_data;
  logic [8:0]   glyphs_loaded;

  font_ram_loader dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .err(err), .glyphs_loaded(glyphs_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0, bad = 0;

  logic [7:0]   got_addr[$];
  logic [0:127] got_data[$];
  int           got_cyc[$];
  logic [7:0]   exp_addr[$];
  logic [0:127] exp_data[$];
  int           exp_loaded = 0;
  int           err_seen = 0, last_err_cyc = -1, ready_viol = 0;
  bit           mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (wr_en) begin
        got_addr.push_back(wr_addr);
        got_data.push_back(wr_data);
        got_cyc.push_back(cyc);
      end
      if (err) begin
        err_seen++;
        last_err_cyc = cyc;
      end
      if (in_ready === wr_en) ready_viol++;
    end
  end

  function automatic logic [0:127] pack_glyph(input logic [7:0] rows[16]);
    logic [0:127] g;
    for (int r = 0; r < 16; r++)
      for (int x = 0; x < 8; x++)
        g[r*8 + x] = rows[r][7 - x];
    return g;
  endfunction

  task automatic clear_queues();
    got_addr.delete(); got_data.delete(); got_cyc.delete();
    exp_addr.delete(); exp_data.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall, input bit ab, output int hs);
    if (stall) begin
      int g = $urandom_range(0, 3);
      repeat (g) begin in_valid = 1'b0; @(posedge clk); #1; end
    end
    in_valid = 1'b1; in_data = b; abort = ab;
    hs = -1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (in_ready) begin hs = cyc; break; end
    end
    if (hs < 0) begin
      vecs++; bad++;
      $display("FAIL handshake_timeout byte=%02h in_ready=%b required=1", b, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; abort = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] rows[16], input bit badk,
                            input bit stall, input int abort_byte, input bit abort_wr,
                            output int first_hs, output int last_hs);
    logic [7:0] k = c;
    logic [7:0] b;
    int hs;
    for (int i = 0; i < 16; i++) k ^= rows[i];
    if (badk) k ^= 8'h01;
    for (int i = 0; i < 18; i++) begin
      b = (i == 0) ? c : (i == 17) ? k : rows[i-1];
      send_byte(b, stall, i == abort_byte, hs);
      if (i == 0) first_hs = hs;
      last_hs = hs;
      if (i == abort_byte) return;
    end
    if (!badk) begin
      exp_addr.push_back(c);
      exp_data.push_back(pack_glyph(rows));
      if (exp_loaded < 511) exp_loaded++;
    end
    if (abort_wr) begin
      abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    end
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vecs++; if ({in_ready, busy, wr_en, err} !== 4'b0) begin bad++;
      $display("FAIL reset_flags got=%b required=0000", {in_ready, busy, wr_en, err}); end
    vecs++; if (wr_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h required=00", wr_addr); end
    vecs++; if (wr_data !== 128'h0) begin bad++; $display("FAIL reset_data got=%h required=0", wr_data); end
    vecs++; if (glyphs_loaded !== 9'd0) begin bad++; $display("FAIL reset_count got=%0d required=0", glyphs_loaded); end
    rst_n = 1'b1; #1;
    vecs++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge got=%b required=0", in_ready); end
    @(posedge clk); #1;
    vecs++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ready_after_edge got=%b required=1", in_ready); end
    mon_en = 1'b1;
  endtask

  task automatic test_valid();
    logic [7:0] rows[16] = '{8'h00, 8'h18, 8'h24, 8'h42, 8'h42, 8'h7E, 8'h42, 8'h42,
                             8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [0:127] d;
    int f, l;
    clear_queues();
    send_frame(8'h41, rows, 1'b0, 1'b0, -1, 1'b0, f, l);
    settle();
    vecs++; if (got_addr.size() != 1) begin bad++; $display("FAIL valid_writes got=%0d required=1", got_addr.size()); end
    if (got_addr.size() > 0) begin
      d = got_data[0];
      vecs++; if (got_addr[0] !== 8'h41) begin bad++; $display("FAIL valid_addr got=%h required=41", got_addr[0]); end
      vecs++; if (d[8:15] !== 8'h18) begin bad++; $display("FAIL valid_row1 got=%h required=18", d[8:15]); end
      vecs++; if (d !== exp_data[0]) begin bad++; $display("FAIL valid_data got=%h required=%h", d, exp_data[0]); end
      vecs++; if (got_cyc[0] - f != 18) begin bad++; $display("FAIL valid_latency got=%0d required=18", got_cyc[0] - f); end
    end
    vecs++; if (glyphs_loaded !== 9'(exp_loaded)) begin bad++;
      $display("FAIL valid_count got=%0d required=%0d", glyphs_loaded, exp_loaded); end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] rows[16];
    int f, l, e0 = err_seen;
    for (int i = 0; i < 16; i++) rows[i] = 8'($urandom);
    clear_queues();
    send_frame(8'h41, rows, 1'b1, 1'b0, -1, 1'b0, f, l);
    settle();
    vecs++; if (got_addr.size() != 0) begin bad++; $display("FAIL bad_no_write got=%0d required=0", got_addr.size()); end
    vecs++; if (err_seen - e0 != 1) begin bad++; $display("FAIL bad_err_pulses got=%0d required=1", err_seen - e0); end
    vecs++; if (last_err_cyc != l + 1) begin bad++; $display("FAIL bad_err_cycle got=%0d required=%0d", last_err_cyc, l + 1); end
    vecs++; if (glyphs_loaded !== 9'(exp_loaded)) begin bad++;
      $display("FAIL bad_count got=%0d required=%0d", glyphs_loaded, exp_loaded); end
    for (int i = 0; i < 16; i++) rows[i] = 8'($urandom);
    send_frame(8'($urandom), rows, 1'b0, 1'b0, -1, 1'b0, f, l);
    settle();
    vecs++; if (got_addr.size() != 1) begin bad++; $display("FAIL bad_next_writes got=%0d required=1", got_addr.size()); end
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      vecs++; if ({got_addr[i], got_data[i]} !== {exp_addr[i], exp_data[i]}) begin bad++;
        $display("FAIL bad_next_write got=%h/%h required=%h/%h", got_addr[i], got_data[i], exp_addr[i], exp_data[i]); end
    end
  endtask

  task automatic test_stalls();
    logic [7:0] rows[16];
    logic [7:0] c;
    int f, l;
    clear_queues();
    for (int n = 0; n < 6; n++) begin
      if (n % 2 == 0) begin
        c = 8'($urandom);
        for (int i = 0; i < 16; i++) rows[i] = 8'($urandom);
      end
      send_frame(c, rows, 1'b0, n % 2 == 1, -1, 1'b0, f, l);
    end
    settle();
    vecs++; if (got_addr.size() != 6) begin bad++; $display("FAIL stall_writes got=%0d required=6", got_addr.size()); end
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      vecs++; if ({got_addr[i], got_data[i]} !== {exp_addr[i], exp_data[i]}) begin bad++;
        $display("FAIL stall_write got=%h/%h required=%h/%h", got_addr[i], got_data[i], exp_addr[i], exp_data[i]); end
    end
    vecs++; if (ready_viol != 0) begin bad++; $display("FAIL ready_only_low_in_write violations=%0d required=0", ready_viol); end
  endtask

  task automatic test_abort();
    logic [7:0] rows[16];
    int f, l;
    clear_queues();
    for (int i = 0; i < 16; i++) rows[i] = 8'($urandom);
    send_frame(8'h55, rows, 1'b0, 1'b1, 8, 1'b0, f, l);
    vecs++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b required=0", busy); end
    for (int i = 0; i < 16; i++) rows[i] = 8'($urandom);
    send_frame(8'h42, rows, 1'b0, 1'b1, -1, 1'b0, f, l);
    for (int i = 0; i < 16; i++) rows[i] = 8'($urandom);
    send_frame(8'($urandom), rows, 1'b0, 1'b0, -1, 1'b1, f, l);
    settle();
    vecs++; if (got_addr.size() != 2) begin bad++; $display("FAIL abort_writes got=%0d required=2", got_addr.size()); end
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      vecs++; if ({got_addr[i], got_data[i]} !== {exp_addr[i], exp_data[i]}) begin bad++;
        $display("FAIL abort_write got=%h/%h required=%h/%h", got_addr[i], got_data[i], exp_addr[i], exp_data[i]); end
    end
    vecs++; if (glyphs_loaded !== 9'(exp_loaded)) begin bad++;
      $display("FAIL abort_count got=%0d required=%0d", glyphs_loaded, exp_loaded); end
  endtask

  task automatic test_reset_mid_frame();
    int hs;
    clear_queues();
    send_byte(8'h33, 1'b0, 1'b0, hs);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b0, 1'b0, hs);
    in_valid = 1'b1; in_data = 8'($urandom);
    #2 rst_n = 1'b0;
    #1;
    vecs++; if ({in_ready, busy, wr_en, err, wr_addr, wr_data, glyphs_loaded} !== '0) begin bad++;
      $display("FAIL midreset_outputs ready=%b busy=%b wr_en=%b err=%b addr=%h count=%0d required=all 0",
               in_ready, busy, wr_en, err, wr_addr, glyphs_loaded); end
    mon_en = 1'b0; in_valid = 1'b0; exp_loaded = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    vecs++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midreset_ready_release got=%b required=0", in_ready); end
    @(posedge clk); #1;
    vecs++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midreset_ready_edge got=%b required=1", in_ready); end
    mon_en = 1'b1;
    settle();
    vecs++; if (got_addr.size() != 0 || glyphs_loaded !== 9'd0) begin bad++;
      $display("FAIL midreset_no_write writes=%0d count=%0d required=0/0", got_addr.size(), glyphs_loaded); end
  endtask

  task automatic test_saturation();
    logic [7:0] rows[16];
    int f, l, mis = 0;
    clear_queues();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 16; i++) rows[i] = 8'($urandom);
      send_frame(8'($urandom), rows, 1'b0, 1'b0, -1, 1'b0, f, l);
    end
    settle();
    vecs++; if (glyphs_loaded !== 9'(exp_loaded) || exp_loaded != 511) begin bad++;
      $display("FAIL sat_count got=%0d required=511", glyphs_loaded); end
    vecs++; if (got_addr.size() != 600) begin bad++; $display("FAIL sat_writes got=%0d required=600", got_addr.size()); end
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
      if ({got_addr[i], got_data[i]} !== {exp_addr[i], exp_data[i]}) mis++;
    vecs++; if (mis != 0) begin bad++; $display("FAIL sat_write_data wrong=%0d required=0", mis); end
    vecs++; if (ready_viol != 0) begin bad++; $display("FAIL sat_ready violations=%0d required=0", ready_viol); end
  endtask

  initial begin
    test_reset();
    test_valid();
    test_bad_checksum();
    test_stalls();
    test_abort();
    test_reset_mid_frame();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end
endmodule

// File: doc/font_ram_loader.md
# font_ram_loader

Fills the text-mode font RAM that the GPU pixel path reads: it accepts a byte stream of glyph frames (character code, 16 row bytes, checksum) over a valid/ready handshake, assembles each 128-bit glyph, and issues one write per verified frame. The block sits between the CPU/UART byte source and the write port of the dual-port font RAM. The RAM's read side keeps the existing layout: 256 glyphs × 128 bits, bit index `row*8 + x`, bit 0 = top-left pixel.

## Interface
- `GLYPH_COUNT`, 256: glyphs in the font RAM; `wr_addr` width = `$clog2(GLYPH_COUNT)`.
- `CHAR_W`, 8: pixels per glyph row, which is also bits per row byte.
- `GLYPH_ROWS`, 16: stored rows per glyph; `GLYPH_BITS = CHAR_W*GLYPH_ROWS` = 128.
- `CLOCK_50` input 1: the single clock; all logic is on its rising edge.
- `RESET_N` input 1: asynchronous, active-low reset.
- `in_data` input 8: stream byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: the loader accepts a byte this cycle. Transfer occurs when `in_valid & in_ready`.
- `abort` input 1: discard the current frame and return to IDLE.
- `wr_en` output 1: one-cycle write strobe to the font RAM.
- `wr_addr` output 8: glyph index, equal to the frame's character code.
- `wr_data` output [0:127]: glyph bits, in the same big-endian layout as the storage.
- `busy` output 1: high while a frame is in progress (any state except IDLE).
- `err` output 1: one-cycle pulse on checksum mismatch.
- `glyphs_loaded` output 9: count of successful writes; saturates at 511.

## Operation
- Frame format: byte 0 is the code C. Bytes 1..16 are rows R0..R15. Byte 17 is the checksum K = C ^ R0 ^ … ^ R15.
- Row packing: the bit7 of Rr maps to `wr_data[r*8+0]` (leftmost pixel), and bit0 maps to `wr_data[r*8+7]`. Rows 16–19 of the 20-line cell are not stored; the reader blanks them.
- States:
  - IDLE: `in_ready`=1. On transfer, latch C, clear the row counter, seed the running XOR with C, and go to ROWS.
  - ROWS: `in_ready`=1. Each transfer writes a byte into the row slot at the counter position, XORs it into the running XOR, and increments the counter. The transfer with counter = 15 moves the FSM to CHECK.
  - CHECK: `in_ready`=1. On transfer:
    - If the byte equals the running XOR, go to WRITE.
    - Otherwise pulse `err` in the next cycle, make no write, and go to IDLE.
  - WRITE: `in_ready`=0. `wr_en`=1 for exactly this cycle, with `wr_addr`=C and `wr_data`=the assembled glyph. `glyphs_loaded` increments unless it is already 511. Next state is IDLE.
- `in_valid` low simply stalls the FSM in its current state; there is no timeout.
- `abort` is sampled every cycle:
  - When high, the next state is IDLE, and any byte handshaken in that cycle is discarded.
  - An abort during WRITE does not suppress that cycle's write, because the frame was already verified.
  - An abort in IDLE has no effect.
- Rewriting the same code overwrites the glyph; no duplicate check is made.
- The glyph buffer keeps stale bits between frames. Every row is overwritten before any write, so this is invisible at `wr_data`.

## Timing
- Reset values: all outputs are 0 (`in_ready`=0, `busy`=0, `wr_en`=0, `err`=0, `wr_addr`=0, `wr_data`=0, `glyphs_loaded`=0) and the state is IDLE.
- `in_ready` goes to 1 at the first `CLOCK_50` edge after `RESET_N` deasserts.
- All outputs are registered. `in_ready` and `busy` are decodes of the state register.
- Latency: `wr_en` is high in the cycle after the checksum transfer.
- Throughput: with `in_valid` held high, one glyph takes 19 cycles (18 transfers plus 1 WRITE cycle in which `in_ready` is low).
- `err` is high for one cycle, the cycle after the bad checksum. `in_ready` is already 1 in that cycle, so a new frame may start there.
- A mid-frame reset clears everything asynchronously; no partial write occurs.

## Structure
- `font_pkg` holds the following, shared with the GPU font reader:
  - the constants `CHAR_W`=8, `GLYPH_ROWS`=16, `CELL_H`=20 and `GLYPH_COUNT`=256;
  - the state enum (IDLE, ROWS, CHECK, WRITE).
- No sub-module: the row buffer, counter, XOR accumulator and FSM fit in a single module.

## Test plan
- Valid frame: C=0x41, R0..R15=0x00,0x18,0x24,…, correct K, `in_valid` held high → exactly one `wr_en` 18 cycles after the first byte, with `wr_addr`=0x41, `wr_data[8:15]`=0x18, and `glyphs_loaded`=1.
- Bad checksum: the same frame with K^0x01 → no `wr_en`, a one-cycle `err` pulse, `glyphs_loaded` unchanged, and the next valid frame is accepted normally.
- Stalls: random `in_valid` gaps → `wr_data` is identical to the no-stall case, and `in_ready` is low only in the WRITE cycle.
- Abort:
  - `abort` at row 7 → `busy` drops the next cycle and no write occurs.
  - A following frame for C=0x42 writes correctly.
  - `abort` asserted during WRITE → the write still occurs.
- Reset mid-frame: `RESET_N` pulsed low at row 10 → all outputs are 0 immediately, `in_ready` returns to 1 one edge after release, and there is no write.
- Saturation: 600 valid frames → `glyphs_loaded` stops at 511, and the writes continue.
